// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, with early exit
// on the first differing slice and optional two's-complement mode.
module seq_magnitude_comparator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sb, sa_next, sb_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             gt_next, eq_next, lt_next;
  logic [DIGIT-1:0] top_a, top_b;

  assign top_a = sa[WIDTH-1 -: DIGIT];
  assign top_b = sb[WIDTH-1 -: DIGIT];

  // Next-state, operand shift and flag update
  always_comb begin
    state_next = state;
    sa_next    = sa;
    sb_next    = sb;
    cnt_next   = cnt;
    gt_next    = gt;
    eq_next    = eq;
    lt_next    = lt;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          // Flipping the sign bit maps two's-complement order onto unsigned order
          sa_next    = {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
          sb_next    = {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
          cnt_next   = '0;
          gt_next    = 1'b0;
          eq_next    = 1'b0;
          lt_next    = 1'b0;
          state_next = CMP;
        end else begin
          state_next = IDLE;
        end
      end
      CMP: begin
        if (top_a > top_b) begin
          gt_next    = 1'b1;
          state_next = DONE;
        end else if (top_a < top_b) begin
          lt_next    = 1'b1;
          state_next = DONE;
        end else if (cnt == CW'(N - 1)) begin
          eq_next    = 1'b1;
          state_next = DONE;
        end else begin
          sa_next  = sa << DIGIT;
          sb_next  = sb << DIGIT;
          cnt_next = cnt + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      sa    <= sa_next;
      sb    <= sb_next;
      cnt   <= cnt_next;
      gt    <= gt_next;
      eq    <= eq_next;
      lt    <= lt_next;
      busy  <= (state_next == CMP);
      done  <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator (WIDTH=8, DIGIT=2): vector table
// plus hand-written handshake and reset sequences.
module tb_seq_magnitude_comparator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       signed_mode;
  logic [7:0] a, b;
  logic       busy, done, gt, eq, lt;

  int n_cmp = 0;
  int n_err = 0;

  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sm;
    logic [2:0] flags;  // {gt, eq, lt}
    int         lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive a start pulse; returns at #1 after the accepting edge
  task automatic start_cmp(input logic [7:0] va, input logic [7:0] vb, input logic sm);
    @(negedge clk);
    a = va; b = vb; signed_mode = sm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'h5A; b = 8'hC3; signed_mode = ~sm;
  endtask

  // Count edges until done is seen (bounded); leaves time at #1 after that edge
  task automatic wait_done(output int lat);
    lat = 99;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    vecs[0]  = '{8'hA5, 8'h25, 1'b0, 3'b100, 1};
    vecs[1]  = '{8'h3C, 8'h3C, 1'b0, 3'b010, 4};
    vecs[2]  = '{8'hFF, 8'h01, 1'b1, 3'b001, 1};
    vecs[3]  = '{8'hFF, 8'h01, 1'b0, 3'b100, 1};
    vecs[4]  = '{8'h80, 8'h7F, 1'b1, 3'b001, 1};
    vecs[5]  = '{8'h80, 8'h81, 1'b0, 3'b001, 4};
    vecs[6]  = '{8'h81, 8'h80, 1'b0, 3'b100, 4};
    vecs[7]  = '{8'hFF, 8'hFF, 1'b1, 3'b010, 4};
    vecs[8]  = '{8'h00, 8'hFF, 1'b1, 3'b100, 1};
    vecs[9]  = '{8'h40, 8'h50, 1'b0, 3'b001, 2};
    vecs[10] = '{8'h0C, 8'h08, 1'b0, 3'b100, 3};

    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      start_cmp(vecs[i].a, vecs[i].b, vecs[i].sm);
      chk($sformatf("v%0d_busy_flags", i), {28'd0, busy, gt, eq, lt}, 32'h8);
      wait_done(lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_flags", i), {29'd0, gt, eq, lt}, {29'd0, vecs[i].flags});
      chk($sformatf("v%0d_busy_at_done", i), {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_after", i), {27'd0, busy, done, gt, eq, lt},
          {27'd0, 2'b00, vecs[i].flags});
    end

    // Flags hold through idle cycles after an equal result
    start_cmp(8'h3C, 8'h3C, 1'b0);
    wait_done(lat);
    chk("hold_lat", 32'(lat), 32'd4);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_idle%0d", c), {27'd0, busy, done, gt, eq, lt}, 32'h02);
    end

    // Start pulse while busy is ignored
    start_cmp(8'h3C, 8'h3C, 1'b0);
    @(negedge clk);
    a = 8'h00; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ignore_busy", {31'd0, busy}, 32'd1);
    wait_done(lat);
    chk("ignore_lat", 32'(lat + 1), 32'd4);
    chk("ignore_flags", {29'd0, gt, eq, lt}, 32'h2);

    // Back-to-back: start held through DONE
    start_cmp(8'hA5, 8'h25, 1'b0);
    wait_done(lat);
    chk("b2b_first_lat", 32'(lat), 32'd1);
    a = 8'h10; b = 8'h20; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_restart", {27'd0, busy, done, gt, eq, lt}, 32'h10);
    wait_done(lat);
    chk("b2b_second_lat", 32'(lat), 32'd2);
    chk("b2b_second_flags", {29'd0, gt, eq, lt}, 32'h1);

    // Reset during cycle 2 of an equal compare aborts without a done pulse
    start_cmp(8'h3C, 8'h3C, 1'b0);
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_outputs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
    @(negedge clk); rst = 1'b0;
    begin
      int seen = 0;
      for (int c = 0; c < 6; c++) begin
        @(posedge clk); #1;
        if (done || busy) seen++;
      end
      chk("abort_no_done", 32'(seen), 32'd0);
    end
    start_cmp(8'h3C, 8'h3C, 1'b0);
    wait_done(lat);
    chk("post_reset_lat", 32'(lat), 32'd4);
    chk("post_reset_flags", {29'd0, gt, eq, lt}, 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
